pio_out_pulse: RTL and testbench

//  Parametrised Avalon-MM output PIO for the Nios subsystem; successor to the fixed 12-bit data-out port.

---
 rtl/pio_out_pkg.sv | 24 ++
 rtl/pio_pulse_timer.sv | 73 +++++++
 rtl/pio_out_pulse.sv | 144 ++++++++++++++
 tb/tb_pio_out_pulse.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_out_pkg.sv
// Shared constants and types for the pulse-capable output PIO.
package pio_out_pkg;

  // Word addresses of the register map
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_PMASK  = 3'd4;
  localparam logic [2:0] ADDR_PLEN   = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;

  // Bit positions inside the CTRL register
  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IRQEN = 2;

  // Pulse engine state
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot pulse timer: counts a latched length down and flags completion.
// o_busy_next / o_done_pulse describe what happens at the coming edge so the
// parent can register its outputs from next-state values.
module pio_pulse_timer
  import pio_out_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_busy_next,
  output logic             o_done_pulse
);

  pulse_state_t     r_state;
  pulse_state_t     w_state_next;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_next;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; a start always wins over the running count (retrigger)
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_done_pulse = 1'b0;
    if (i_start) begin
      if (i_len != '0) begin
        w_state_next = ACTIVE;
        w_cnt_next   = i_len;
      end else begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        o_done_pulse = 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = IDLE;
        end
        ACTIVE: begin
          if (r_cnt == LEN_W'(1'b1)) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            o_done_pulse = 1'b1;
          end else begin
            w_cnt_next   = r_cnt - LEN_W'(1'b1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign o_busy      = (r_state == ACTIVE);
  assign o_busy_next = (w_state_next == ACTIVE);

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with atomic SET/CLEAR/TOGGLE, a one-shot pulse engine
// that inverts masked bits for a programmed number of clocks, and a sticky
// done flag with optional level interrupt.
module pio_out_pulse
  import pio_out_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    LEN_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_pmask;
  logic [LEN_W-1:0]      r_plen;
  logic [DATA_WIDTH-1:0] r_mask_act;
  logic                  r_done;
  logic                  r_irq_en;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_irq;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_done_clr;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [DATA_WIDTH-1:0] w_mask_next;
  logic                  w_done_next;
  logic                  w_irq_en_next;
  logic                  w_busy;
  logic                  w_busy_next;
  logic                  w_done_pulse;

  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[DATA_WIDTH-1:0];
  assign w_ctrl_wr  = w_wr && (address == ADDR_CTRL);
  assign w_start    = w_ctrl_wr & writedata[CTRL_START];
  assign w_done_clr = w_ctrl_wr & writedata[CTRL_DONE];

  pio_pulse_timer #(
    .LEN_W (LEN_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_start),
    .i_len        (r_plen),
    .o_busy       (w_busy),
    .o_busy_next  (w_busy_next),
    .o_done_pulse (w_done_pulse)
  );

  // Data register next value: plain, set, clear and toggle writes
  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_next = w_wd;
        ADDR_SET:    w_data_next = r_data | w_wd;
        ADDR_CLEAR:  w_data_next = r_data & ~w_wd;
        ADDR_TOGGLE: w_data_next = r_data ^ w_wd;
        default:     w_data_next = r_data;
      endcase
    end else begin
      w_data_next = r_data;
    end
  end

  // Pulse mask latch, sticky done (completion beats clear) and irq enable
  always_comb begin
    w_mask_next   = r_mask_act;
    w_done_next   = r_done;
    w_irq_en_next = r_irq_en;
    if (w_start && (r_plen != '0)) begin
      w_mask_next = r_pmask;
    end else begin
      w_mask_next = r_mask_act;
    end
    if (w_done_pulse) begin
      w_done_next = 1'b1;
    end else if (w_done_clr) begin
      w_done_next = 1'b0;
    end else begin
      w_done_next = r_done;
    end
    if (w_ctrl_wr) begin
      w_irq_en_next = writedata[CTRL_IRQEN];
    end else begin
      w_irq_en_next = r_irq_en;
    end
  end

  // Register file plus outputs registered from next-state values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= RESET_VALUE;
      r_pmask    <= '0;
      r_plen     <= '0;
      r_mask_act <= '0;
      r_done     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_out      <= RESET_VALUE;
      r_irq      <= 1'b0;
    end else begin
      r_data     <= w_data_next;
      r_mask_act <= w_mask_next;
      r_done     <= w_done_next;
      r_irq_en   <= w_irq_en_next;
      if (w_wr && (address == ADDR_PMASK)) begin
        r_pmask <= w_wd;
      end
      if (w_wr && (address == ADDR_PLEN)) begin
        r_plen <= writedata[LEN_W-1:0];
      end
      r_out <= w_data_next ^ (w_busy_next ? w_mask_next : {DATA_WIDTH{1'b0}});
      r_irq <= w_done_next & w_irq_en_next;
    end
  end

  // Zero-latency read mux, zero-extended; write-only and unmapped read 0
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:  readdata = 32'(r_data);
      ADDR_PMASK: readdata = 32'(r_pmask);
      ADDR_PLEN:  readdata = 32'(r_plen);
      ADDR_CTRL:  readdata = {29'd0, r_irq_en, r_done, w_busy};
      default:    readdata = 32'd0;
    endcase
  end

  assign out_port = r_out;
  assign irq      = r_irq;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Self-checking bench for pio_out_pulse: directed scenarios plus random bus
// traffic compared each cycle against a behavioural model of the register map.
module tb_pio_out_pulse;

  localparam int              DW = 12;
  localparam int              LW = 16;
  localparam logic [DW-1:0]   RV = 12'h0A5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic          irq;

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;

  // Behavioural model: register contents plus clocks of pulse still to run
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_pmask;
  logic [LW-1:0] m_plen;
  logic [DW-1:0] m_mask;
  logic          m_done;
  logic          m_irqen;
  int            m_rem;

  pio_out_pulse #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RV),
    .LEN_W       (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data  = RV;
    m_pmask = '0;
    m_plen  = '0;
    m_mask  = '0;
    m_done  = 1'b0;
    m_irqen = 1'b0;
    m_rem   = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {20'd0, m_data};
      3'd4:    return {20'd0, m_pmask};
      3'd5:    return {16'd0, m_plen};
      3'd6:    return {29'd0, m_irqen, m_done, (m_rem > 0)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] model_out();
    return (m_rem > 0) ? (m_data ^ m_mask) : m_data;
  endfunction

  // Advance the model by one clock edge with the access presented during it
  task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic wr;
    logic fin;
    wr  = cs & ~wn;
    fin = 1'b0;
    if (wr && a == 3'd6 && wd[0]) begin
      if (m_plen != '0) begin
        m_rem  = int'(m_plen);
        m_mask = m_pmask;
      end else begin
        m_rem = 0;
        fin   = 1'b1;
      end
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) fin = 1'b1;
    end
    if (wr) begin
      case (a)
        3'd0: m_data = wd[DW-1:0];
        3'd1: m_data = m_data | wd[DW-1:0];
        3'd2: m_data = m_data & ~wd[DW-1:0];
        3'd3: m_data = m_data ^ wd[DW-1:0];
        3'd4: m_pmask = wd[DW-1:0];
        3'd5: m_plen = wd[LW-1:0];
        3'd6: begin
          m_irqen = wd[2];
          if (wd[1]) m_done = 1'b0;
        end
        default: ;
      endcase
    end
    if (fin) m_done = 1'b1;
  endtask

  // One bus cycle: drive after negedge, check read, clock, check outputs
  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    #1;
    check_val("readdata", readdata, model_read(a));
    @(posedge clk);
    model_edge(cs, wn, a, wd);
    @(negedge clk);
    check_val("out_port", {20'd0, out_port}, {20'd0, model_out()});
    check_val("irq", {31'd0, irq}, {31'd0, m_done & m_irqen});
    if (out_port[0] === 1'b1) hi_cnt++;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic read_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    writedata  = 32'd0;
    #1;
    check_val(tag, readdata, exp);
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rw;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    model_reset();
    #1;
    // 1: reset values and truncated DATA write
    check_val("rst_read0", readdata, 32'h0000_00A5);
    check_val("rst_out", {20'd0, out_port}, 32'h0A5);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr(3'd0, 32'hFFFF_F123);
    check_val("t1_out", {20'd0, out_port}, 32'h123);
    read_expect("t1_read", 3'd0, 32'h0000_0123);

    // 2: atomic set/clear/toggle and write-only reads
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0F0);
    check_val("t2_set", {20'd0, out_port}, 32'h0F0);
    wr(3'd2, 32'h030);
    check_val("t2_clr", {20'd0, out_port}, 32'h0C0);
    wr(3'd3, 32'h801);
    check_val("t2_tgl", {20'd0, out_port}, 32'h8C1);
    rd(3'd1); rd(3'd2); rd(3'd3); rd(3'd7);
    read_expect("t2_read7", 3'd7, 32'd0);

    // 3: five-clock pulse with irq
    wr(3'd0, 32'h0);
    wr(3'd4, 32'h001);
    wr(3'd5, 32'd5);
    hi_cnt = 0;
    wr(3'd6, 32'h5);
    repeat (9) idle();
    check_val("t3_len", hi_cnt, 32'd5);
    check_val("t3_irq", {31'd0, irq}, 32'd1);
    read_expect("t3_ctrl", 3'd6, 32'h6);
    wr(3'd6, 32'h2);
    check_val("t3_irq_clr", {31'd0, irq}, 32'd0);

    // 4: retrigger shortens the pulse; zero length completes at once
    wr(3'd5, 32'd10);
    hi_cnt = 0;
    wr(3'd6, 32'h1);
    idle(); idle();
    wr(3'd5, 32'd3);
    wr(3'd6, 32'h1);
    repeat (10) idle();
    check_val("t4_len", hi_cnt, 32'd7);
    wr(3'd6, 32'h2);
    wr(3'd5, 32'd0);
    hi_cnt = 0;
    wr(3'd6, 32'h1);
    check_val("t4_zero_len", hi_cnt, 32'd0);
    read_expect("t4_zero_done", 3'd6, 32'h2);

    // 5: toggle during pulse, then asynchronous reset mid-pulse
    wr(3'd5, 32'd8);
    wr(3'd6, 32'h1);
    idle();
    wr(3'd3, 32'h100);
    check_val("t5_tgl", {20'd0, out_port}, 32'h101);
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_rst_out", {20'd0, out_port}, 32'h0A5);
    read_expect("t5_rst_ctrl", 3'd6, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // 6: done-clear on the completion edge leaves done set
    wr(3'd4, 32'h001);
    wr(3'd5, 32'd2);
    wr(3'd6, 32'h1);
    idle();
    wr(3'd6, 32'h2);
    read_expect("t6_done", 3'd6, 32'h2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ra = 3'($urandom_range(0, 7));
      rw = $urandom;
      if (ra == 3'd5) rw = (rw & 32'hFFFF_0000) | 32'($urandom_range(0, 8));
      cycle(($urandom_range(0, 7) != 0), 1'($urandom), ra, rw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
